// File: rtl/riscv_defs.sv
// Shared encodings for the multicycle RV32I control path: opcodes, mux selects,
// ALU codes and the controller state enumeration.
package riscv_defs;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] I_T = 3'b000;
    localparam logic [2:0] S_T = 3'b001;
    localparam logic [2:0] J_T = 3'b010;
    localparam logic [2:0] B_T = 3'b011;
    localparam logic [2:0] U_T = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return S_T;
            OP_BRANCH: return B_T;
            OP_JAL:    return J_T;
            OP_LUI:    return U_T;
            default:   return I_T;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an ALU control code.
module alu_decoder
    import riscv_defs::*;
#(
    parameter int W = 3
) (
    input  logic          op5,
    input  logic [2:0]    funct3,
    input  logic          funct7b5,
    input  alu_op_t       alu_op,
    output logic [W-1:0]  alu_control
);

    always_comb begin
        alu_control = W'(ALU_ADD);
        case (alu_op)
            ALUOP_SUB: alu_control = W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 is an immediate bit for addi, so only R-type may subtract
                    3'b000:  alu_control = (op5 & funct7b5) ? W'(ALU_SUB) : W'(ALU_ADD);
                    3'b111:  alu_control = W'(ALU_AND);
                    3'b110:  alu_control = W'(ALU_OR);
                    3'b100:  alu_control = W'(ALU_XOR);
                    3'b010:  alu_control = W'(ALU_SLT);
                    default: alu_control = W'(ALU_ADD);
                endcase
            end
            default: alu_control = W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute
// and writeback over the shared datapath, with memory-ready stalls.
module multicycle_controller
    import riscv_defs::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         ALU_CTRL_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  neg,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic                  instr_done,
    output logic                  illegal
);

    state_t                state_reg, state_next;
    alu_op_t               alu_op;
    logic [ALU_CTRL_W-1:0] alu_ctrl_dec;
    logic                  taken;
    logic                  pc_write_c, adr_src_c, mem_write_c, ir_write_c;
    logic                  reg_write_c, instr_done_c, illegal_c;
    logic [1:0]            result_src_c, src_a_c, src_b_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= state_t'(RESET_STATE);
        else      state_reg <= state_next;
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = S_FETCH;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RD2;
        alu_op       = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
                state_next   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively form OldPC+imm so BRANCH/JAL find their target in ALUOut
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    default: begin
                        illegal_c    = 1'b1;
                        instr_done_c = 1'b1;
                        state_next   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c  = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_c    = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = mem_ready;
                state_next   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                src_a_c    = SRCA_RD1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                src_a_c      = SRCA_RD1;
                alu_op       = ALUOP_SUB;
                pc_write_c   = taken;
                instr_done_c = 1'b1;
            end
            S_JAL: begin
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                state_next = S_JALR2;
            end
            S_JALR2: begin
                // PC takes the target from ALUOut while the ALU forms the link value
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                result_src_c = RES_IMMEXT;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    alu_decoder #(.W(ALU_CTRL_W)) u_alu_decoder (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_op     (alu_op),
        .alu_control(alu_ctrl_dec)
    );

    // Reset forces every output low, independent of the state register
    assign pc_write    = rst & pc_write_c;
    assign adr_src     = rst & adr_src_c;
    assign mem_write   = rst & mem_write_c;
    assign ir_write    = rst & ir_write_c;
    assign reg_write   = rst & reg_write_c;
    assign instr_done  = rst & instr_done_c;
    assign illegal     = rst & illegal_c;
    assign result_src  = rst ? result_src_c : 2'b00;
    assign alu_src_a   = rst ? src_a_c : 2'b00;
    assign alu_src_b   = rst ? src_b_c : 2'b00;
    assign alu_control = rst ? alu_ctrl_dec : '0;
    assign imm_src     = rst ? imm_sel(op) : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction vectors with a
// scoreboard of expected results, plus reset-in-flight sequences.
module tb_multicycle_controller;
    import riscv_defs::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, neg, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [18:0] outs;

    always #5 clk = ~clk;

    assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal};

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, zero, neg;
        int         fs, ms;          // stall cycles in FETCH and in MEMREAD/MEMWRITE
        int         cyc;
        int         imm;
        int         nreg, npc, nmw, nill;
        int         p;               // probe cycle offset after the fetch stalls
        int         alu, rs, pcw;    // expected alu_control/result_src/pc_write at the probe
    } vec_t;

    vec_t vecs[19];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic n, input int fs, input int ms,
                                input int cyc, input int imm, input int nreg, input int npc,
                                input int nmw, input int nill, input int p, input int alu,
                                input int rs, input int pcw);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.neg = n; v.fs = fs; v.ms = ms;
        v.cyc = cyc; v.imm = imm; v.nreg = nreg; v.npc = npc; v.nmw = nmw; v.nill = nill;
        v.p = p; v.alu = alu; v.rs = rs; v.pcw = pcw;
        return v;
    endfunction

    // Called one step after a rising edge with the DUT sitting in FETCH.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   cyc = 0, nreg = 0, npc = 0, nmw = 0, nill = 0, nir = 0;
        int   imm_seen = -1, alu_seen = -1, rs_seen = -1, pcw_seen = -1;
        int   probe;
        bit   done = 0;
        sb.push_back(v);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.zero; neg = v.neg;
        probe = v.fs + v.p + ((v.p >= 4) ? v.ms : 0);
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = !((c < v.fs) || (c >= v.fs + 3 && c < v.fs + 3 + v.ms));
            @(negedge clk);
            npc  += int'(pc_write);
            nreg += int'(reg_write);
            nmw  += int'(mem_write);
            nill += int'(illegal);
            nir  += int'(ir_write);
            if (c == v.fs + 1) imm_seen = int'(imm_src);
            if (c == probe) begin
                alu_seen = int'(alu_control);
                rs_seen  = int'(result_src);
                pcw_seen = int'(pc_write);
            end
            if (instr_done) begin
                done = 1;
                cyc  = c + 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            check($sformatf("v%0d_timeout", idx), 0, 1);
            void'(sb.pop_back());
            rst = 1'b0; #2; rst = 1'b1;
            @(posedge clk); #1;
        end else begin
            e = sb.pop_front();
            $display("[TB] v%0d op=%b f3=%b cycles=%0d reg=%0d pc=%0d mw=%0d ill=%0d",
                     idx, v.op, v.f3, cyc, nreg, npc, nmw, nill);
            check($sformatf("v%0d_cycles", idx), cyc, e.cyc);
            check($sformatf("v%0d_imm_src", idx), imm_seen, e.imm);
            check($sformatf("v%0d_reg_write", idx), nreg, e.nreg);
            check($sformatf("v%0d_pc_write", idx), npc, e.npc);
            check($sformatf("v%0d_mem_write", idx), nmw, e.nmw);
            check($sformatf("v%0d_illegal", idx), nill, e.nill);
            check($sformatf("v%0d_ir_write", idx), nir, 1);
            check($sformatf("v%0d_probe_alu", idx), alu_seen, e.alu);
            check($sformatf("v%0d_probe_rs", idx), rs_seen, e.rs);
            check($sformatf("v%0d_probe_pcw", idx), pcw_seen, e.pcw);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, nmw;
        bit done;
        //           op         f3      f7 z  n  fs ms cyc imm reg pc mw il p  alu rs pcw
        vecs[0]  = mk(OP_RTYPE,  3'b000, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 0, 0, 0); // add
        vecs[1]  = mk(OP_RTYPE,  3'b000, 1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 1, 0, 0); // sub
        vecs[2]  = mk(OP_LOAD,   3'b010, 0, 0, 0, 2, 2, 9, 0, 1, 1, 0, 0, 4, 0, 1, 0); // lw stalled
        vecs[3]  = mk(OP_STORE,  3'b010, 0, 0, 0, 0, 1, 5, 1, 0, 1, 2, 0, 3, 0, 0, 0); // sw stalled
        vecs[4]  = mk(OP_BRANCH, 3'b000, 0, 1, 0, 0, 0, 3, 3, 0, 2, 0, 0, 2, 1, 0, 1); // beq taken
        vecs[5]  = mk(OP_BRANCH, 3'b001, 0, 1, 0, 0, 0, 3, 3, 0, 1, 0, 0, 2, 1, 0, 0); // bne not taken
        vecs[6]  = mk(OP_BRANCH, 3'b100, 0, 0, 1, 0, 0, 3, 3, 0, 2, 0, 0, 2, 1, 0, 1); // blt taken
        vecs[7]  = mk(OP_BRANCH, 3'b101, 0, 0, 1, 0, 0, 3, 3, 0, 1, 0, 0, 2, 1, 0, 0); // bge not taken
        vecs[8]  = mk(OP_BRANCH, 3'b010, 0, 1, 1, 0, 0, 3, 3, 0, 1, 0, 0, 2, 1, 0, 0); // bad funct3
        vecs[9]  = mk(OP_JAL,    3'b000, 0, 0, 0, 0, 0, 4, 2, 1, 2, 0, 0, 2, 0, 0, 1); // jal
        vecs[10] = mk(OP_JALR,   3'b000, 0, 0, 0, 0, 0, 5, 0, 1, 2, 0, 0, 2, 0, 0, 0); // jalr: JALR
        vecs[11] = mk(OP_JALR,   3'b000, 0, 0, 0, 0, 0, 5, 0, 1, 2, 0, 0, 3, 0, 0, 1); // jalr: JALR2
        vecs[12] = mk(OP_LUI,    3'b000, 0, 0, 0, 0, 0, 3, 4, 1, 1, 0, 0, 2, 0, 3, 0); // lui
        vecs[13] = mk(7'b1111111,3'b000, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 1, 1, 0, 0, 0); // illegal
        vecs[14] = mk(OP_ITYPE,  3'b100, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 4, 0, 0); // xori
        vecs[15] = mk(OP_ITYPE,  3'b000, 1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 0, 0, 0); // addi, imm bit30
        vecs[16] = mk(OP_RTYPE,  3'b111, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 2, 0, 0); // and
        vecs[17] = mk(OP_ITYPE,  3'b110, 0, 0, 0, 1, 0, 5, 0, 1, 1, 0, 0, 0, 0, 2, 1); // ori, FETCH probe
        vecs[18] = mk(OP_RTYPE,  3'b010, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2, 5, 0, 0); // slt

        rst = 1'b0; mem_ready = 1'b1; op = OP_LUI; funct3 = 3'b000;
        funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
        @(negedge clk);
        $display("[TB] reset outs=%h", outs);
        check("reset_outputs", int'(outs), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // Reset while a store is held in MEMWRITE
        op = OP_STORE; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("rst_mw_before", int'(mem_write), 1);
        #1 rst = 1'b0;
        #1;
        $display("[TB] reset mid-MEMWRITE mem_write=%b outs=%h", mem_write, outs);
        check("rst_mw_drop", int'(mem_write), 0);
        check("rst_mw_all_zero", int'(outs), 0);
        @(posedge clk); #2;
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        $display("[TB] after release pc_write=%b ir_write=%b adr_src=%b", pc_write, ir_write, adr_src);
        check("rel_pc_write", int'(pc_write), 1);
        check("rel_ir_write", int'(ir_write), 1);
        check("rel_adr_src", int'(adr_src), 0);
        check("rel_result_src", int'(result_src), 2);
        @(posedge clk); #1;
        cnt = 0; nmw = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            cnt++;
            nmw += int'(mem_write);
            if (instr_done) done = 1;
            @(posedge clk); #1;
        end
        $display("[TB] store after reset remaining_cycles=%0d mem_write=%0d", cnt, nmw);
        check("rel_store_cycles", cnt, 3);
        check("rel_store_mw", nmw, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
